// File: rtl/alu4_pkg.sv
// Shared types for the 4-bit ALU self-test: operation encoding and sweep size.
package alu4_pkg;
    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        AND = 2'd2,
        OR  = 2'd3
    } alu_op_t;

    localparam int NUM_VECTORS = 1024;
endpackage

// File: rtl/alu4_golden.sv
// Combinational reference model of the 4-bit ALU; overflow is unsigned carry/borrow.
module alu4_golden
    import alu4_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  alu_op_t    op,
    output logic [3:0] result,
    output logic       overflow
);
    logic [4:0] sum;

    always_comb begin
        sum      = {1'b0, a} + {1'b0, b};
        result   = '0;
        overflow = 1'b0;
        case (op)
            ADD: {overflow, result} = sum;
            SUB: begin
                result   = a - b;
                overflow = (a < b);
            end
            AND: result = a & b;
            OR:  result = a | b;
            default: ;
        endcase
    end
endmodule

// File: rtl/alu4_bist.sv
// Exhaustive self-test sweep of a 4-bit ALU against alu4_golden.
// Define ALU4_BIST_FAIL_CAPTURE_EN to add first-failure capture outputs.
module alu4_bist
    import alu4_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output alu_op_t     alu_op,
    input  logic [3:0]  alu_result,
    input  logic        alu_overflow,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [10:0] err_count
`ifdef ALU4_BIST_FAIL_CAPTURE_EN
    ,
    output logic        fail_valid,
    output alu_op_t     fail_op,
    output logic [3:0]  fail_a,
    output logic [3:0]  fail_b,
    output logic [3:0]  fail_result,
    output logic        fail_overflow
`endif
);
    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, FINISH} state_t;

    localparam logic [3:0]  SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [9:0]  IDX_LAST    = 10'(NUM_VECTORS - 1);
    localparam logic [10:0] ERR_MAX     = 11'h7FF;

    state_t      state_q, state_d;
    logic [9:0]  idx_q, idx_d;
    logic [3:0]  settle_q, settle_d;
    logic [10:0] err_q, err_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;

    logic [3:0]  gold_result;
    logic        gold_overflow;
    logic        mismatch;

    // Operands come straight from the index so the ALU sees them the cycle DRIVE begins.
    assign alu_op    = alu_op_t'(idx_q[9:8]);
    assign alu_a     = idx_q[7:4];
    assign alu_b     = idx_q[3:0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign err_count = err_q;

    alu4_golden u_golden (
        .a        (alu_a),
        .b        (alu_b),
        .op       (alu_op),
        .result   (gold_result),
        .overflow (gold_overflow)
    );

    assign mismatch = ({alu_overflow, alu_result} != {gold_overflow, gold_result});

`ifdef ALU4_BIST_FAIL_CAPTURE_EN
    logic       fail_valid_q, fail_valid_d;
    alu_op_t    fail_op_q, fail_op_d;
    logic [3:0] fail_a_q, fail_a_d;
    logic [3:0] fail_b_q, fail_b_d;
    logic [3:0] fail_result_q, fail_result_d;
    logic       fail_overflow_q, fail_overflow_d;

    assign fail_valid    = fail_valid_q;
    assign fail_op       = fail_op_q;
    assign fail_a        = fail_a_q;
    assign fail_b        = fail_b_q;
    assign fail_result   = fail_result_q;
    assign fail_overflow = fail_overflow_q;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        settle_d = settle_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = done_q;
        pass_d   = pass_q;
`ifdef ALU4_BIST_FAIL_CAPTURE_EN
        fail_valid_d    = fail_valid_q;
        fail_op_d       = fail_op_q;
        fail_a_d        = fail_a_q;
        fail_b_d        = fail_b_q;
        fail_result_d   = fail_result_q;
        fail_overflow_d = fail_overflow_q;
`endif
        case (state_q)
            IDLE, FINISH: begin
                if (start) begin
                    state_d  = DRIVE;
                    idx_d    = '0;
                    settle_d = '0;
                    err_d    = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    pass_d   = 1'b0;
`ifdef ALU4_BIST_FAIL_CAPTURE_EN
                    fail_valid_d    = 1'b0;
                    fail_op_d       = ADD;
                    fail_a_d        = '0;
                    fail_b_d        = '0;
                    fail_result_d   = '0;
                    fail_overflow_d = 1'b0;
`endif
                end
            end
            DRIVE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d  = CHECK;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_q != ERR_MAX) err_d = err_q + 11'd1;
`ifdef ALU4_BIST_FAIL_CAPTURE_EN
                    if (!fail_valid_q) begin
                        fail_valid_d    = 1'b1;
                        fail_op_d       = alu_op;
                        fail_a_d        = alu_a;
                        fail_b_d        = alu_b;
                        fail_result_d   = alu_result;
                        fail_overflow_d = alu_overflow;
                    end
`endif
                end
                // pass uses err_d so a mismatch on the last vector lands with done.
                if (idx_q == IDX_LAST) begin
                    state_d = FINISH;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == '0);
                end else begin
                    state_d = DRIVE;
                    idx_d   = idx_q + 10'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            settle_q <= '0;
            err_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
`ifdef ALU4_BIST_FAIL_CAPTURE_EN
            fail_valid_q    <= 1'b0;
            fail_op_q       <= ADD;
            fail_a_q        <= '0;
            fail_b_q        <= '0;
            fail_result_q   <= '0;
            fail_overflow_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            settle_q <= settle_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
`ifdef ALU4_BIST_FAIL_CAPTURE_EN
            fail_valid_q    <= fail_valid_d;
            fail_op_q       <= fail_op_d;
            fail_a_q        <= fail_a_d;
            fail_b_q        <= fail_b_d;
            fail_result_q   <= fail_result_d;
            fail_overflow_q <= fail_overflow_d;
`endif
        end
    end
endmodule

// File: tb/tb_alu4_bist.sv
// Bench for alu4_bist: a SETTLE_CYCLES=1 instance driven by a faultable ALU model,
// and a SETTLE_CYCLES=3 instance driven by an ALU with two cycles of output latency.
module tb_alu4_bist;
    import alu4_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int mode     = 0;

    // Instance with SETTLE_CYCLES=1
    logic        start1 = 1'b0;
    logic [3:0]  a1, b1, res1;
    alu_op_t     op1;
    logic        ovf1, busy1, done1, pass1;
    logic [10:0] err1;
`ifdef ALU4_BIST_FAIL_CAPTURE_EN
    logic        fv1, fovf1;
    alu_op_t     fop1;
    logic [3:0]  fa1, fb1, fres1;
`endif

    // Instance with SETTLE_CYCLES=3
    logic        start3 = 1'b0;
    logic [3:0]  a3, b3;
    alu_op_t     op3;
    logic        busy3, done3, pass3;
    logic [10:0] err3;
    logic [4:0]  dly1, dly2;
`ifdef ALU4_BIST_FAIL_CAPTURE_EN
    logic        fv3, fovf3;
    alu_op_t     fop3;
    logic [3:0]  fa3, fb3, fres3;
`endif

    // ALU under test; mode 1: ADD carry stuck at 0, mode 2: OR computes AND.
    function automatic logic [4:0] alu_model(input int m, input logic [1:0] op,
                                             input logic [3:0] a, input logic [3:0] b);
        logic [4:0] r;
        case (op)
            2'd0: begin
                r = {1'b0, a} + {1'b0, b};
                if (m == 1) r[4] = 1'b0;
            end
            2'd1: r = {(a < b), 4'(a - b)};
            2'd2: r = {1'b0, a & b};
            default: r = (m == 2) ? {1'b0, a & b} : {1'b0, a | b};
        endcase
        return r;
    endfunction

    always_comb {ovf1, res1} = alu_model(mode, op1, a1, b1);

    always @(posedge clk) begin
        dly1 <= alu_model(0, op3, a3, b3);
        dly2 <= dly1;
    end

    alu4_bist #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .alu_a(a1), .alu_b(b1), .alu_op(op1),
        .alu_result(res1), .alu_overflow(ovf1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
`ifdef ALU4_BIST_FAIL_CAPTURE_EN
        , .fail_valid(fv1), .fail_op(fop1), .fail_a(fa1), .fail_b(fb1),
        .fail_result(fres1), .fail_overflow(fovf1)
`endif
    );

    alu4_bist #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3),
        .alu_a(a3), .alu_b(b3), .alu_op(op3),
        .alu_result(dly2[3:0]), .alu_overflow(dly2[4]),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3)
`ifdef ALU4_BIST_FAIL_CAPTURE_EN
        , .fail_valid(fv3), .fail_op(fop3), .fail_a(fa3), .fail_b(fb3),
        .fail_result(fres3), .fail_overflow(fovf3)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_reset1(input string tag);
        chk({tag, "_alu_a"}, int'(a1), 0);
        chk({tag, "_alu_b"}, int'(b1), 0);
        chk({tag, "_alu_op"}, int'(op1), 0);
        chk({tag, "_busy"}, int'(busy1), 0);
        chk({tag, "_done"}, int'(done1), 0);
        chk({tag, "_pass"}, int'(pass1), 0);
        chk({tag, "_err"}, int'(err1), 0);
    endtask

    // Start a sweep on dut1 and return edges from the start-sampling edge to done.
    task automatic sweep1(input bit hold, output int n);
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start1 = 1'b0;
        chk("busy_after_start", int'(busy1), 1);
        chk("err_cleared_on_start", int'(err1), 0);
        n = 0;
        while (n < 5000) begin
            @(posedge clk);
            n++;
            #1;
            if (done1) break;
        end
    endtask

    typedef struct {
        string name;
        int    mode;
        int    exp_err;
        int    exp_pass;
    } sweep_vec_t;

    sweep_vec_t tbl[3];

    initial begin
        int n;
        tbl[0] = '{"good_alu",     0, 0,   1};
        tbl[1] = '{"add_ovf_zero", 1, 120, 0};
        tbl[2] = '{"or_as_and",    2, 240, 0};

        #12;
        chk_reset1("por");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            mode = tbl[i].mode;
            sweep1(1'b0, n);
            chk({tbl[i].name, "_cycles"}, n, 2048);
            chk({tbl[i].name, "_done"}, int'(done1), 1);
            chk({tbl[i].name, "_busy"}, int'(busy1), 0);
            chk({tbl[i].name, "_err"}, int'(err1), tbl[i].exp_err);
            chk({tbl[i].name, "_pass"}, int'(pass1), tbl[i].exp_pass);
`ifdef ALU4_BIST_FAIL_CAPTURE_EN
            chk({tbl[i].name, "_fail_valid"}, int'(fv1), (tbl[i].exp_err != 0) ? 1 : 0);
            if (tbl[i].mode == 1) begin
                chk("cap_op", int'(fop1), 0);
                chk("cap_a", int'(fa1), 1);
                chk("cap_b", int'(fb1), 15);
                chk("cap_result", int'(fres1), 0);
                chk("cap_overflow", int'(fovf1), 0);
            end
`endif
        end

        // Reset 500 cycles into a sweep
        mode = 0;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        repeat (500) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_reset1("mid_rst");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_rst_busy", int'(busy1), 0);
        chk("idle_after_rst_done", int'(done1), 0);
        sweep1(1'b0, n);
        chk("post_rst_cycles", n, 2048);
        chk("post_rst_err", int'(err1), 0);
        chk("post_rst_pass", int'(pass1), 1);

        // start held high for the whole sweep
        sweep1(1'b1, n);
        chk("held_cycles", n, 2048);
        chk("held_err", int'(err1), 0);
        chk("held_pass", int'(pass1), 1);
        @(posedge clk);
        #1;
        chk("held_relaunch_busy", int'(busy1), 1);
        chk("held_relaunch_done", int'(done1), 0);
        chk("held_relaunch_pass", int'(pass1), 0);
        chk("held_relaunch_err", int'(err1), 0);
        start1 = 1'b0;
        rst = 1'b1;
        #1;
        rst = 1'b0;

        // SETTLE_CYCLES=3 against a two-cycle-latency ALU
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        chk("s3_busy", int'(busy3), 1);
        n = 0;
        while (n < 9000) begin
            @(posedge clk);
            n++;
            #1;
            if (done3) break;
        end
        chk("s3_cycles", n, 4096);
        chk("s3_err", int'(err3), 0);
        chk("s3_pass", int'(pass3), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
